// File: rtl/bsg_manycore_loader_arbiter.sv
// Round-robin arbiter sharing the host loader link among several requesters,
// with a one-entry output stage, outstanding-request credits and a drain FSM.
module bsg_manycore_loader_arbiter #(
   parameter int num_req_p         = 4,
   parameter int packet_width_p    = 128,
   parameter int rsp_width_p       = 64,
   parameter int max_out_credits_p = 16,
   parameter int id_width_lp       = (num_req_p > 1) ? $clog2(num_req_p) : 1,
   parameter int credit_width_lp   = $clog2(max_out_credits_p + 1)
) (
   input  logic                                  clk_i,
   input  logic                                  reset_n_i,

   input  logic [num_req_p-1:0]                  req_v_i,
   input  logic [num_req_p*packet_width_p-1:0]   req_packet_i,
   output logic [num_req_p-1:0]                  req_ready_o,

   output logic                                  out_v_o,
   output logic [packet_width_p-1:0]             out_packet_o,
   output logic [id_width_lp-1:0]                out_id_o,
   input  logic                                  out_ready_i,

   input  logic                                  rsp_v_i,
   input  logic [rsp_width_p-1:0]                rsp_data_i,
   input  logic [id_width_lp-1:0]                rsp_id_i,
   output logic                                  rsp_yumi_o,

   output logic [num_req_p-1:0]                  rsp_v_o,
   output logic [rsp_width_p-1:0]                rsp_data_o,
   input  logic [num_req_p-1:0]                  rsp_ready_i,

   input  logic                                  drain_i,
   output logic                                  drained_o,
   output logic [credit_width_lp-1:0]            credits_o,
   output logic [1:0]                            state_o
);

   // Handshakes: a transfer happens on a cycle where valid & ready are both
   // high; valid never waits on ready, and a valid payload stays stable until
   // it transfers. rsp_yumi_o is the consume strobe for the endpoint response.

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_DRAIN   = 2'd1,
      ST_DRAINED = 2'd2
   } state_e;

   localparam logic [credit_width_lp-1:0] credits_max_lp = credit_width_lp'(max_out_credits_p);
   localparam logic [credit_width_lp-1:0] credit_one_lp  = credit_width_lp'(1);
   localparam logic [id_width_lp-1:0]     last_init_lp   = id_width_lp'(num_req_p - 1);

   state_e                       state_r, state_n;
   logic                         stage_v_r, stage_v_n;
   logic [packet_width_p-1:0]    stage_packet_r;
   logic [id_width_lp-1:0]       stage_id_r;
   logic [credit_width_lp-1:0]   credits_r, credits_n;
   logic [id_width_lp-1:0]       last_r;

   logic                         can_grant;
   logic                         grant_found;
   logic                         grant;
   logic [id_width_lp-1:0]       grant_idx;
   logic [id_width_lp-1:0]       cand;
   logic [packet_width_p-1:0]    grant_packet;
   logic                         id_ok;
   logic                         rsp_ready_sel;

   // ---------------------------------------------------------------
   // Grant selection
   // ---------------------------------------------------------------
   assign can_grant = reset_n_i
                    & (state_r == ST_RUN)
                    & (credits_r != '0)
                    & (~stage_v_r | out_ready_i);

   // Search starts just after the last winner, so every valid requester is
   // served within num_req_p grants.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_r;
      cand        = '0;
      for (int k = 1; k <= num_req_p; k++) begin
         cand = id_width_lp'((int'(last_r) + k) % num_req_p);
         if (!grant_found && req_v_i[cand]) begin
            grant_found = 1'b1;
            grant_idx   = cand;
         end
      end
   end

   assign grant = can_grant & grant_found;

   always_comb begin
      req_ready_o = '0;
      if (grant) begin
         req_ready_o[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      grant_packet = '0;
      for (int i = 0; i < num_req_p; i++) begin
         if (grant_idx == id_width_lp'(i)) begin
            grant_packet = req_packet_i[i*packet_width_p +: packet_width_p];
         end
      end
   end

   // ---------------------------------------------------------------
   // Response steering
   // ---------------------------------------------------------------
   assign id_ok = (int'(rsp_id_i) < num_req_p);

   always_comb begin
      rsp_v_o       = '0;
      rsp_ready_sel = 1'b0;
      for (int i = 0; i < num_req_p; i++) begin
         if (int'(rsp_id_i) == i) begin
            rsp_v_o[i]    = rsp_v_i;
            rsp_ready_sel = rsp_ready_i[i];
         end
      end
   end

   // A response carrying an out-of-range id is swallowed so the link cannot jam.
   assign rsp_yumi_o = rsp_v_i & (id_ok ? rsp_ready_sel : 1'b1);
   assign rsp_data_o = rsp_data_i;

   // ---------------------------------------------------------------
   // Credits and output stage next values
   // ---------------------------------------------------------------
   always_comb begin
      credits_n = credits_r;
      case ({grant, rsp_yumi_o})
         2'b10: credits_n = credits_r - credit_one_lp;
         2'b01: if (credits_r != credits_max_lp) credits_n = credits_r + credit_one_lp;
         default: credits_n = credits_r;
      endcase
   end

   always_comb begin
      stage_v_n = stage_v_r;
      if (grant) begin
         stage_v_n = 1'b1;
      end else if (out_ready_i) begin
         stage_v_n = 1'b0;
      end
   end

   // ---------------------------------------------------------------
   // Drain FSM
   // ---------------------------------------------------------------
   // DRAINED is judged on next-cycle values so it shows up the cycle right
   // after the final yumi or dequeue.
   always_comb begin
      state_n = state_r;
      case (state_r)
         ST_RUN: begin
            if (drain_i) state_n = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!drain_i) begin
               state_n = ST_RUN;
            end else if (!stage_v_n && (credits_n == credits_max_lp)) begin
               state_n = ST_DRAINED;
            end
         end
         ST_DRAINED: begin
            if (!drain_i) state_n = ST_RUN;
         end
         default: state_n = ST_RUN;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r        <= ST_RUN;
         stage_v_r      <= 1'b0;
         stage_packet_r <= '0;
         stage_id_r     <= '0;
         credits_r      <= credits_max_lp;
         last_r         <= last_init_lp;
      end else begin
         state_r   <= state_n;
         stage_v_r <= stage_v_n;
         credits_r <= credits_n;
         if (grant) begin
            stage_packet_r <= grant_packet;
            stage_id_r     <= grant_idx;
            last_r         <= grant_idx;
         end
      end
   end

   assign out_v_o      = stage_v_r;
   assign out_packet_o = stage_packet_r;
   assign out_id_o     = stage_id_r;
   assign credits_o    = credits_r;
   assign drained_o    = (state_r == ST_DRAINED);
   assign state_o      = state_r;

   // ---------------------------------------------------------------
   // Protocol checks
   // ---------------------------------------------------------------
   a_rsp_id_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(rsp_v_i && !id_ok));

   a_credit_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(rsp_yumi_o && (credits_r == credits_max_lp)));

endmodule
